// File: rtl/pcileech_tlps128_src_demux.sv
// Purpose: classify each RX TLP on its first beat and steer the whole packet to CFG/CPL/MEM/OTHER.
// Latency: one register stage; an accepted beat appears on out_* the following cycle.
// Backpressure: in_tready follows the selected port's ready; dropped packets are always consumed.
module pcileech_tlps128_src_demux #(
   parameter int CNT_W = 16
) (
   input  logic               clk_pcie,
   input  logic               rst,
   input  logic [127:0]       in_tdata,
   input  logic [3:0]         in_tkeepdw,
   input  logic               in_tlast,
   input  logic [8:0]         in_tuser,
   input  logic               in_tvalid,
   output logic               in_tready,
   input  logic [3:0]         port_en,
   output logic [127:0]       out_tdata,
   output logic [3:0]         out_tkeepdw,
   output logic               out_tlast,
   output logic [8:0]         out_tuser,
   output logic [3:0]         out_tvalid,
   input  logic [3:0]         out_tready,
   output logic [CNT_W-1:0]   drop_count,
   output logic [CNT_W-1:0]   err_count,
   output logic [CNT_W-1:0]   pkt_count_cpl
);

   typedef enum logic {ST_IDLE, ST_PKT} state_t;

   localparam logic [1:0] PORT_CFG   = 2'd0;
   localparam logic [1:0] PORT_CPL   = 2'd1;
   localparam logic [1:0] PORT_MEM   = 2'd2;
   localparam logic [1:0] PORT_OTHER = 2'd3;

   state_t             state_q, state_d;
   logic [1:0]         route_q, route_d;        // route of the packet currently arriving
   logic               drop_q, drop_d;          // current packet is being discarded
   logic               orphan_q, orphan_d;      // inside a run of headless beats
   logic               out_valid_q, out_valid_d;
   logic [1:0]         out_port_q, out_port_d;  // route of the beat held in the output register
   logic [127:0]       out_tdata_q, out_tdata_d;
   logic [3:0]         out_tkeepdw_q, out_tkeepdw_d;
   logic               out_tlast_q, out_tlast_d;
   logic [8:0]         out_tuser_q, out_tuser_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   pkt_cpl_q, pkt_cpl_d;

   logic               fire;
   logic               out_hs;
   logic               load;
   logic [1:0]         load_port;
   logic [1:0]         cls;

   // First-beat classification from the fmt/type byte (DW0[31:24]).
   function automatic logic [1:0] classify(input logic [7:0] fmt_type);
      logic [6:0] ft;
      ft = fmt_type[7:1];
      if (ft == 7'b0000010 || ft == 7'b0100010)
         return PORT_CFG;
      else if (ft == 7'b0000101 || ft == 7'b0100101)
         return PORT_CPL;
      else if (fmt_type[4:0] == 5'b00000)
         return PORT_MEM;
      else
         return PORT_OTHER;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Handshake, packet tracking, output register and counter next-state.
   always_comb begin
      state_d       = state_q;
      route_d       = route_q;
      drop_d        = drop_q;
      orphan_d      = orphan_q;
      out_valid_d   = out_valid_q;
      out_port_d    = out_port_q;
      out_tdata_d   = out_tdata_q;
      out_tkeepdw_d = out_tkeepdw_q;
      out_tlast_d   = out_tlast_q;
      out_tuser_d   = out_tuser_q;
      drop_cnt_d    = drop_cnt_q;
      err_cnt_d     = err_cnt_q;
      pkt_cpl_d     = pkt_cpl_q;
      load          = 1'b0;
      load_port     = route_q;

      in_tready = !out_valid_q || out_tready[out_port_q] || drop_q;
      fire      = in_tvalid && in_tready;
      out_hs    = out_valid_q && out_tready[out_port_q];
      cls       = classify(in_tdata[31:24]);

      if (fire) begin
         if (in_tuser[0]) begin
            // A header inside an open packet abandons the old route without a tlast.
            if (state_q == ST_PKT)
               err_cnt_d = sat_inc(err_cnt_q);
            orphan_d = 1'b0;
            route_d  = cls;
            if (!port_en[cls]) begin
               drop_d     = 1'b1;
               drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
               drop_d    = 1'b0;
               load      = 1'b1;
               load_port = cls;
            end
            if (in_tlast) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
            end else begin
               state_d = ST_PKT;
            end
         end else if (state_q == ST_PKT) begin
            load = !drop_q;
            if (in_tlast) begin
               state_d = ST_IDLE;
               drop_d  = 1'b0;
            end
         end else begin
            // Headless beat outside a packet: swallow it, count the run once.
            if (!orphan_q) begin
               err_cnt_d = sat_inc(err_cnt_q);
               orphan_d  = 1'b1;
            end
         end
      end

      if (out_hs) begin
         out_valid_d = 1'b0;
         if (out_tlast_q && out_port_q == PORT_CPL)
            pkt_cpl_d = pkt_cpl_q + 1'b1;
      end

      // A load in the same cycle as the handshake refills without a bubble.
      if (load) begin
         out_valid_d   = 1'b1;
         out_port_d    = load_port;
         out_tdata_d   = in_tdata;
         out_tkeepdw_d = in_tkeepdw;
         out_tlast_d   = in_tlast;
         out_tuser_d   = in_tuser;
      end
   end

   // State, output and counter registers with synchronous reset.
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         route_q       <= 2'd0;
         drop_q        <= 1'b0;
         orphan_q      <= 1'b0;
         out_valid_q   <= 1'b0;
         out_port_q    <= 2'd0;
         out_tdata_q   <= '0;
         out_tkeepdw_q <= '0;
         out_tlast_q   <= 1'b0;
         out_tuser_q   <= '0;
         drop_cnt_q    <= '0;
         err_cnt_q     <= '0;
         pkt_cpl_q     <= '0;
      end else begin
         state_q       <= state_d;
         route_q       <= route_d;
         drop_q        <= drop_d;
         orphan_q      <= orphan_d;
         out_valid_q   <= out_valid_d;
         out_port_q    <= out_port_d;
         out_tdata_q   <= out_tdata_d;
         out_tkeepdw_q <= out_tkeepdw_d;
         out_tlast_q   <= out_tlast_d;
         out_tuser_q   <= out_tuser_d;
         drop_cnt_q    <= drop_cnt_d;
         err_cnt_q     <= err_cnt_d;
         pkt_cpl_q     <= pkt_cpl_d;
      end
   end

   assign out_tvalid    = out_valid_q ? (4'b0001 << out_port_q) : 4'b0000;
   assign out_tdata     = out_tdata_q;
   assign out_tkeepdw   = out_tkeepdw_q;
   assign out_tlast     = out_tlast_q;
   assign out_tuser     = out_tuser_q;
   assign drop_count    = drop_cnt_q;
   assign err_count     = err_cnt_q;
   assign pkt_count_cpl = pkt_cpl_q;

endmodule

// File: tb/tb_pcileech_tlps128_src_demux.sv
// Directed bench for the RX TLP demux: routing, drop, stall, orphan and header-restart cases.
// Inputs change on the falling edge; outputs are observed shortly after it.
// Output handshakes are logged by a monitor and compared against hand-written expectations.
module tb_pcileech_tlps128_src_demux;

   localparam int CNT_W = 16;

   logic               clk_pcie = 1'b0;
   logic               rst = 1'b1;
   logic [127:0]       in_tdata = '0;
   logic [3:0]         in_tkeepdw = '0;
   logic               in_tlast = 1'b0;
   logic [8:0]         in_tuser = '0;
   logic               in_tvalid = 1'b0;
   logic               in_tready;
   logic [3:0]         port_en = 4'hF;
   logic [127:0]       out_tdata;
   logic [3:0]         out_tkeepdw;
   logic               out_tlast;
   logic [8:0]         out_tuser;
   logic [3:0]         out_tvalid;
   logic [3:0]         out_tready = 4'hF;
   logic [CNT_W-1:0]   drop_count;
   logic [CNT_W-1:0]   err_count;
   logic [CNT_W-1:0]   pkt_count_cpl;

   pcileech_tlps128_src_demux #(.CNT_W(CNT_W)) dut (
      .clk_pcie      (clk_pcie),
      .rst           (rst),
      .in_tdata      (in_tdata),
      .in_tkeepdw    (in_tkeepdw),
      .in_tlast      (in_tlast),
      .in_tuser      (in_tuser),
      .in_tvalid     (in_tvalid),
      .in_tready     (in_tready),
      .port_en       (port_en),
      .out_tdata     (out_tdata),
      .out_tkeepdw   (out_tkeepdw),
      .out_tlast     (out_tlast),
      .out_tuser     (out_tuser),
      .out_tvalid    (out_tvalid),
      .out_tready    (out_tready),
      .drop_count    (drop_count),
      .err_count     (err_count),
      .pkt_count_cpl (pkt_count_cpl)
   );

   always #5 clk_pcie = ~clk_pcie;

   typedef struct {
      logic [1:0]   port;
      logic [127:0] data;
      logic [3:0]   keep;
      logic         last;
      int           cyc;
   } rec_t;

   rec_t q[$];
   int   cyc = 0;
   int   nrdy_lo = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = 0;

   always @(posedge clk_pcie) cyc <= cyc + 1;

   // Log every output handshake and count cycles where a valid input beat was refused.
   initial begin
      rec_t r;
      forever begin
         @(negedge clk_pcie);
         #2;
         if (!rst) begin
            if (in_tvalid && !in_tready) nrdy_lo++;
            for (int p = 0; p < 4; p++) begin
               if (out_tvalid[p] && out_tready[p]) begin
                  r.port = p[1:0];
                  r.data = out_tdata;
                  r.keep = out_tkeepdw;
                  r.last = out_tlast;
                  r.cyc  = cyc;
                  q.push_back(r);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] dw0, input logic [31:0] tag);
      return {tag, tag ^ 32'h5555_5555, ~tag, dw0};
   endfunction

   task automatic drive(input logic [127:0] d, input logic [3:0] k, input logic first, input logic last);
      @(negedge clk_pcie);
      in_tdata   = d;
      in_tkeepdw = k;
      in_tuser   = {8'h00, first};
      in_tlast   = last;
      in_tvalid  = 1'b1;
   endtask

   task automatic wait_acc();
      int t;
      for (t = 0; t < 40; t++) begin
         #1;
         if (in_tready) break;
         @(negedge clk_pcie);
      end
      if (t == 40) chk("accept_timeout", 0, 1);
      last_acc = cyc;
      @(posedge clk_pcie);
   endtask

   task automatic send(input logic [127:0] d, input logic [3:0] k, input logic first, input logic last);
      drive(d, k, first, last);
      wait_acc();
   endtask

   task automatic idle(input int n);
      @(negedge clk_pcie);
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      in_tuser  = '0;
      repeat (n) @(negedge clk_pcie);
   endtask

   task automatic do_reset();
      @(negedge clk_pcie);
      rst       = 1'b1;
      in_tvalid = 1'b0;
      repeat (2) @(negedge clk_pcie);
      rst = 1'b0;
      q.delete();
      nrdy_lo = 0;
   endtask

   task automatic expect_beat(input string tag, input logic [1:0] port, input logic [127:0] data,
                              input logic [3:0] keep, input logic last);
      rec_t r;
      if (q.size() == 0) begin
         chk({tag, "_present"}, 0, 1);
         return;
      end
      r = q.pop_front();
      chk({tag, "_port"}, r.port, port);
      chk({tag, "_data"}, r.data, data);
      chk({tag, "_keep"}, r.keep, keep);
      chk({tag, "_last"}, r.last, last);
   endtask

   initial begin
      int a0;

      // Reset state
      do_reset();
      #1;
      chk("rst_tvalid", out_tvalid, 4'b0000);
      chk("rst_tdata", out_tdata, 128'h0);
      chk("rst_tlast", out_tlast, 1'b0);
      chk("rst_tready", in_tready, 1'b1);
      chk("rst_drop", drop_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_pktcpl", pkt_count_cpl, 0);

      // 3-beat CplD on port 1, back-to-back
      send(mk(32'h4A00_0003, 32'hA1), 4'hF, 1'b1, 1'b0);
      a0 = last_acc;
      send(mk(32'h0000_0000, 32'hA2), 4'hF, 1'b0, 1'b0);
      send(mk(32'h0000_0000, 32'hA3), 4'h3, 1'b0, 1'b1);
      idle(3);
      chk("t1_nbeats", q.size(), 3);
      if (q.size() == 3) begin
         chk("t1_cyc0", q[0].cyc, a0 + 1);
         chk("t1_cyc1", q[1].cyc, a0 + 2);
         chk("t1_cyc2", q[2].cyc, a0 + 3);
      end
      expect_beat("t1_b0", 2'd1, mk(32'h4A00_0003, 32'hA1), 4'hF, 1'b0);
      expect_beat("t1_b1", 2'd1, mk(32'h0000_0000, 32'hA2), 4'hF, 1'b0);
      expect_beat("t1_b2", 2'd1, mk(32'h0000_0000, 32'hA3), 4'h3, 1'b1);
      chk("t1_pktcpl", pkt_count_cpl, 1);

      // CfgRd0 single beat, then 2-beat MWr32 back-to-back
      nrdy_lo = 0;
      send(mk(32'h0400_0001, 32'hB1), 4'hF, 1'b1, 1'b1);
      send(mk(32'h4000_0001, 32'hB2), 4'hF, 1'b1, 1'b0);
      send(mk(32'h0000_0000, 32'hB3), 4'h3, 1'b0, 1'b1);
      idle(3);
      expect_beat("t2_cfg", 2'd0, mk(32'h0400_0001, 32'hB1), 4'hF, 1'b1);
      expect_beat("t2_mw0", 2'd2, mk(32'h4000_0001, 32'hB2), 4'hF, 1'b0);
      expect_beat("t2_mw1", 2'd2, mk(32'h0000_0000, 32'hB3), 4'h3, 1'b1);
      chk("t2_tready_low", nrdy_lo, 0);

      // MRd with MEM port disabled is dropped; a following Cpl still goes out
      @(negedge clk_pcie);
      port_en = 4'b1011;
      nrdy_lo = 0;
      send(mk(32'h0000_0001, 32'hC1), 4'hF, 1'b1, 1'b0);
      send(mk(32'h0000_0000, 32'hC2), 4'h3, 1'b0, 1'b1);
      idle(3);
      chk("t3_no_out", q.size(), 0);
      chk("t3_tready_low", nrdy_lo, 0);
      chk("t3_drop", drop_count, 1);
      send(mk(32'h0A00_0001, 32'hC3), 4'h1, 1'b1, 1'b1);
      idle(3);
      expect_beat("t3_cpl", 2'd1, mk(32'h0A00_0001, 32'hC3), 4'h1, 1'b1);
      chk("t3_pktcpl", pkt_count_cpl, 2);
      port_en = 4'hF;

      // CPL port stalls for 5 cycles after the first beat is registered
      send(mk(32'h4A00_0004, 32'hD0), 4'hF, 1'b1, 1'b0);
      drive(mk(32'h0000_0000, 32'hD1), 4'hF, 1'b0, 1'b0);
      out_tready = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_stall_tready", in_tready, 1'b0);
         chk("t4_stall_data", out_tdata, mk(32'h4A00_0004, 32'hD0));
         chk("t4_stall_tvalid", out_tvalid, 4'b0010);
         @(negedge clk_pcie);
      end
      out_tready = 4'hF;
      wait_acc();
      send(mk(32'h0000_0000, 32'hD2), 4'hF, 1'b0, 1'b0);
      send(mk(32'h0000_0000, 32'hD3), 4'h7, 1'b0, 1'b1);
      idle(3);
      expect_beat("t4_b0", 2'd1, mk(32'h4A00_0004, 32'hD0), 4'hF, 1'b0);
      expect_beat("t4_b1", 2'd1, mk(32'h0000_0000, 32'hD1), 4'hF, 1'b0);
      expect_beat("t4_b2", 2'd1, mk(32'h0000_0000, 32'hD2), 4'hF, 1'b0);
      expect_beat("t4_b3", 2'd1, mk(32'h0000_0000, 32'hD3), 4'h7, 1'b1);
      chk("t4_extra", q.size(), 0);
      chk("t4_pktcpl", pkt_count_cpl, 3);

      // Orphan beats after reset, then a CfgWr0
      do_reset();
      #1;
      chk("t5_rst_drop", drop_count, 0);
      chk("t5_rst_pktcpl", pkt_count_cpl, 0);
      send(mk(32'h4A00_0000, 32'hE1), 4'hF, 1'b0, 1'b0);
      send(mk(32'h0000_0000, 32'hE2), 4'hF, 1'b0, 1'b1);
      send(mk(32'h4400_0001, 32'hE3), 4'hF, 1'b1, 1'b1);
      idle(3);
      chk("t5_err", err_count, 1);
      expect_beat("t5_cfgwr", 2'd0, mk(32'h4400_0001, 32'hE3), 4'hF, 1'b1);
      chk("t5_extra", q.size(), 0);

      // New header arrives before tlast of a 4-beat MWr
      do_reset();
      send(mk(32'h4000_0004, 32'hF1), 4'hF, 1'b1, 1'b0);
      send(mk(32'h0000_0000, 32'hF2), 4'hF, 1'b0, 1'b0);
      send(mk(32'h0000_0000, 32'hF3), 4'hF, 1'b0, 1'b0);
      send(mk(32'h4A00_0002, 32'hF4), 4'hF, 1'b1, 1'b0);
      send(mk(32'h0000_0000, 32'hF5), 4'h3, 1'b0, 1'b1);
      idle(3);
      chk("t6_err", err_count, 1);
      expect_beat("t6_mw0", 2'd2, mk(32'h4000_0004, 32'hF1), 4'hF, 1'b0);
      expect_beat("t6_mw1", 2'd2, mk(32'h0000_0000, 32'hF2), 4'hF, 1'b0);
      expect_beat("t6_mw2", 2'd2, mk(32'h0000_0000, 32'hF3), 4'hF, 1'b0);
      expect_beat("t6_cpl0", 2'd1, mk(32'h4A00_0002, 32'hF4), 4'hF, 1'b0);
      expect_beat("t6_cpl1", 2'd1, mk(32'h0000_0000, 32'hF5), 4'h3, 1'b1);
      chk("t6_pktcpl", pkt_count_cpl, 1);
      chk("t6_drop", drop_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
